dekatron_step_sequencer: RTL and testbench

//  Sequencer for a chain of DIGITS dekatron bulbs forming one multi-digit decimal counter.
//  - Accepts increment/decrement/load commands.
//  - Generates the two-phase guide pulses (PulseRight_n/PulseLeft_n) and Set strobes for each bulb.
//  - Keeps a BCD mirror of every bulb position and ripples carry/borrow digit by digit.
//  - Waits for each bulb's Ready before moving on.

---
 rtl/dekatron_step_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dekatron_step_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_step_sequencer.sv
// Step/load sequencer for a chain of dekatron bulbs acting as one decimal counter.
// Drives two-phase guide pulses and set strobes per bulb, mirrors every bulb
// position in BCD and ripples carry/borrow one digit at a time, waiting for each
// bulb to report ready before moving on.
module dekatron_step_sequencer #(
  parameter int DIGITS  = 4,
  parameter int PULSE_W = 3,
  parameter int SET_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  dir_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  error_o,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     pulse_right_n_o,
  output logic [DIGITS-1:0]     pulse_left_n_o,
  output logic [DIGITS-1:0]     set_o,
  output logic [10*DIGITS-1:0]  set_in_o,
  input  logic [DIGITS-1:0]     digit_ready_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PH1, PH2, SETTLE, LOADSET, LOADWAIT, FINISH} state_t;

  state_t               state_q;
  logic                 busy_q, done_q, overflow_q, error_q;
  logic                 dir_q, wrap_q;
  logic [DIGITS-1:0]    sel_q;            // one-hot: bulb currently being stepped
  logic [3:0]           cnt_q;            // phase / set width counter
  logic [TW-1:0]        wait_q;           // ready wait counter
  logic [4*DIGITS-1:0]  value_q, latch_q;
  logic [DIGITS-1:0]    pr_q, pl_q, set_q;
  logic [10*DIGITS-1:0] set_in_q;

  logic [DIGITS-1:0]    load_bad_d;
  logic [4*DIGITS-1:0]  load_clamp_d;
  logic [10*DIGITS-1:0] onehot_d;
  logic [4*DIGITS-1:0]  value_step_d;
  logic [3:0]           cur_digit_d, step_digit_d;
  logic                 step_wrap_d;
  logic                 ready_sel_d;

  // Per-digit load clamping, one-hot set positions and stepped value.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign load_bad_d[gi]            = load_value_i[4*gi +: 4] > 4'd9;
    assign load_clamp_d[4*gi +: 4]   = load_bad_d[gi] ? 4'd0 : load_value_i[4*gi +: 4];
    assign onehot_d[10*gi +: 10]     = 10'd1 << load_clamp_d[4*gi +: 4];
    assign value_step_d[4*gi +: 4]   = sel_q[gi] ? step_digit_d : value_q[4*gi +: 4];
  end

  // Select the active digit and compute its stepped value and wrap.
  always_comb begin
    cur_digit_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) cur_digit_d = value_q[4*i +: 4];
    end
    if (dir_q) begin
      step_wrap_d  = (cur_digit_d == 4'd0);
      step_digit_d = step_wrap_d ? 4'd9 : cur_digit_d - 4'd1;
    end else begin
      step_wrap_d  = (cur_digit_d == 4'd9);
      step_digit_d = step_wrap_d ? 4'd0 : cur_digit_d + 4'd1;
    end
  end

  assign ready_sel_d = |(digit_ready_i & sel_q);

  // Command FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      value_q    <= '0;
      latch_q    <= '0;
      pr_q       <= '1;
      pl_q       <= '1;
      set_q      <= '0;
      set_in_q   <= {DIGITS{10'b0000000001}};
    end else begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_i) begin
            state_q  <= LOADSET;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            latch_q  <= load_clamp_d;
            set_in_q <= onehot_d;
            set_q    <= '1;
            if (|load_bad_d) error_q <= 1'b1;
          end else if (req_i) begin
            state_q <= PH1;
            busy_q  <= 1'b1;
            dir_q   <= dir_i;
            sel_q   <= DIGITS'(1);
            cnt_q   <= '0;
            if (dir_i) pl_q <= ~DIGITS'(1);
            else       pr_q <= ~DIGITS'(1);
          end
        end
        PH1: begin
          if (cnt_q == 4'(PULSE_W - 1)) begin
            state_q <= PH2;
            cnt_q   <= '0;
            // Swap phases on the same edge so they never overlap.
            if (dir_q) begin
              pl_q <= '1;
              pr_q <= ~sel_q;
            end else begin
              pr_q <= '1;
              pl_q <= ~sel_q;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        PH2: begin
          if (cnt_q == 4'(PULSE_W - 1)) begin
            state_q <= SETTLE;
            pr_q    <= '1;
            pl_q    <= '1;
            value_q <= value_step_d;
            wrap_q  <= step_wrap_d;
            wait_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SETTLE: begin
          if (ready_sel_d) begin
            if (wrap_q && !sel_q[DIGITS-1]) begin
              // Ripple into the next more significant bulb.
              state_q <= PH1;
              sel_q   <= sel_q << 1;
              cnt_q   <= '0;
              if (dir_q) pl_q <= ~(sel_q << 1);
              else       pr_q <= ~(sel_q << 1);
            end else begin
              state_q    <= FINISH;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              overflow_q <= wrap_q;
            end
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        LOADSET: begin
          if (cnt_q == 4'(SET_W - 1)) begin
            state_q <= LOADWAIT;
            set_q   <= '0;
            value_q <= latch_q;
            wait_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        LOADWAIT: begin
          if (&digit_ready_i) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overflow_o      = overflow_q;
  assign error_o         = error_q;
  assign value_o         = value_q;
  assign pulse_right_n_o = pr_q;
  assign pulse_left_n_o  = pl_q;
  assign set_o           = set_q;
  assign set_in_o        = set_in_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Randomized scoreboard bench for the dekatron step sequencer. A decimal-integer
// model predicts each command's result, pulse order and set positions; monitors
// compare them as the DUT presents them.
module tb_dekatron_step_sequencer;

  localparam int N   = 4;
  localparam int PW  = 3;
  localparam int SW  = 2;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0, dir = 1'b0, load = 1'b0;
  logic [4*N-1:0]  load_value = '0;
  logic          busy, done, overflow, error;
  logic [4*N-1:0]  value;
  logic [N-1:0]  pr, pl, set;
  logic [10*N-1:0] set_in;
  logic [N-1:0]  ready = '1;

  dekatron_step_sequencer #(.DIGITS(N), .PULSE_W(PW), .SET_W(SW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .dir_i(dir), .load_i(load),
    .load_value_i(load_value), .busy_o(busy), .done_o(done), .overflow_o(overflow),
    .error_o(error), .value_o(value), .pulse_right_n_o(pr), .pulse_left_n_o(pl),
    .set_o(set), .set_in_o(set_in), .digit_ready_i(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*N-1:0] v;
    logic           ov;
    logic           err;
  } res_t;

  res_t           res_q[$];
  logic [4:0]     pulse_q[$];   // {digit, phase}: phase 0 = right, 1 = left
  logic [10*N-1:0] setin_q[$];

  int  checks = 0;
  int  fails  = 0;
  int  txn    = 0;
  int  model_v = 0;
  bit  model_err = 1'b0;
  logic [N-1:0] stuck = '0;
  bit  delay_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  function automatic logic [4*N-1:0] int2bcd(input int v);
    logic [4*N-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit wraps(input bit d, input int digit);
    return d ? (digit == 0) : (digit == 9);
  endfunction

  // Model of a step: the lowest k digits count modulo 10**k.
  task automatic push_step(input bit d);
    int natural, t, s, k, pw, low, newlow;
    bit to, ov;
    res_t r;
    natural = 1;
    t = model_v;
    while (natural < N && wraps(d, t % 10)) begin
      natural++;
      t = t / 10;
    end
    ov = (natural == N) && wraps(d, (model_v / 10**(N-1)) % 10);
    s = N;
    for (int i = N - 1; i >= 0; i--) if (stuck[i]) s = i;
    to = (s < natural);
    k  = to ? s + 1 : natural;
    pw = 10**k;
    low = model_v % pw;
    newlow = d ? (low + pw - 1) % pw : (low + 1) % pw;
    model_v = model_v - low + newlow;
    if (to) model_err = 1'b1;
    for (int j = 0; j < k; j++) begin
      pulse_q.push_back({4'(j), d});
      pulse_q.push_back({4'(j), ~d});
    end
    r.v = int2bcd(model_v);
    r.ov = ov && !to;
    r.err = model_err;
    res_q.push_back(r);
  endtask

  task automatic push_load(input logic [4*N-1:0] lv);
    logic [10*N-1:0] oh;
    res_t r;
    int v, p, dg;
    v = 0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      dg = int'(lv[4*i +: 4]);
      if (dg > 9) begin
        dg = 0;
        model_err = 1'b1;
      end
      oh[10*i +: 10] = 10'd1 << dg;
      v = v + dg * p;
      p = p * 10;
    end
    model_v = v;
    setin_q.push_back(oh);
    r.v = int2bcd(v);
    r.ov = 1'b0;
    r.err = model_err;
    res_q.push_back(r);
  endtask

  task automatic issue(input bit is_load, input bit d, input logic [4*N-1:0] lv, input bit spam);
    int n;
    if (is_load) push_load(lv);
    else         push_step(d);
    @(negedge clk);
    load = is_load;
    req = !is_load;
    dir = d;
    load_value = lv;
    @(negedge clk);
    load = 1'b0;
    req = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (spam && !done) begin
        req = 1'($urandom);
        load = 1'($urandom);
        dir = 1'($urandom);
        load_value = 16'($urandom);
      end else begin
        req = 1'b0;
        load = 1'b0;
      end
      if (n > 2000) begin
        chk("done_within_budget", 1'b0, 1'b1);
        break;
      end
    end
    req = 1'b0;
    load = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [4*N-1:0] rand_bcd();
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) == 0)      r[4*i +: 4] = 4'd9;
      else if ($urandom_range(0, 2) == 0) r[4*i +: 4] = 4'd0;
      else                                r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Bulb model: ready drops while driven and for a random time afterwards.
  int hold[N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!pr[i] || !pl[i] || set[i]) hold[i] = delay_en ? $urandom_range(0, 4) : 0;
      else if (hold[i] > 0) hold[i] = hold[i] - 1;
      ready[i] = !stuck[i] && (hold[i] == 0);
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (done) begin
        if (res_q.size() == 0) begin
          flag("done_unexpected");
        end else begin
          r = res_q.pop_front();
          txn++;
          $display("txn %0d: value=%h ov=%b err=%b (model %h %b %b)", txn, value, overflow, error, r.v, r.ov, r.err);
          chk("value", value, r.v);
          chk("overflow", overflow, r.ov);
          chk("error", error, r.err);
          chk("busy_with_done", busy, 1'b0);
        end
      end
      if (overflow && !done) flag("overflow_without_done");
    end
  end

  // Guide pulse monitor: order, width, overlap.
  int cr[N];
  int cl[N];
  always @(negedge clk) begin
    int active;
    logic [4:0] e;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cr[i] = 0;
        cl[i] = 0;
      end
    end else begin
      active = 0;
      for (int i = 0; i < N; i++) begin
        if (!pr[i] || !pl[i]) active++;
        if (!pr[i] && !pl[i]) flag("phase_overlap");
        if (!pr[i]) begin
          if (cr[i] == 0) begin
            if (pulse_q.size() == 0) flag("pulse_unexpected");
            else begin
              e = pulse_q.pop_front();
              chk("pulse_order", {4'(i), 1'b0}, e);
            end
          end
          cr[i]++;
        end else if (cr[i] != 0) begin
          chk("right_width", cr[i], PW);
          cr[i] = 0;
        end
        if (!pl[i]) begin
          if (cl[i] == 0) begin
            if (pulse_q.size() == 0) flag("pulse_unexpected");
            else begin
              e = pulse_q.pop_front();
              chk("pulse_order", {4'(i), 1'b1}, e);
            end
          end
          cl[i]++;
        end else if (cl[i] != 0) begin
          chk("left_width", cl[i], PW);
          cl[i] = 0;
        end
      end
      if (active > 1) flag("multi_digit_pulse");
    end
  end

  // Set strobe monitor.
  int sc = 0;
  always @(negedge clk) begin
    logic [10*N-1:0] oh;
    if (rst) sc = 0;
    else if (set != '0) begin
      if (sc == 0) begin
        if (setin_q.size() == 0) flag("set_unexpected");
        else begin
          oh = setin_q.pop_front();
          chk("set_in", set_in, oh);
          chk("set_all", set, {N{1'b1}});
        end
      end
      sc++;
    end else if (sc != 0) begin
      chk("set_width", sc, SW);
      sc = 0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_err"}, error, 1'b0);
    chk({tag, "_value"}, value, '0);
    chk({tag, "_pr"}, pr, {N{1'b1}});
    chk({tag, "_pl"}, pl, {N{1'b1}});
    chk({tag, "_set"}, set, '0);
    chk({tag, "_setin"}, set_in, {N{10'b0000000001}});
  endtask

  initial begin
    int n, guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single increment from zero.
    issue(1'b0, 1'b0, '0, 1'b0);
    // Carry ripple across three digits.
    issue(1'b1, 1'b0, 16'h0999, 1'b0);
    issue(1'b0, 1'b0, '0, 1'b0);
    // Full wrap in both directions.
    issue(1'b1, 1'b0, 16'h9999, 1'b0);
    issue(1'b0, 1'b0, '0, 1'b0);
    issue(1'b1, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, '0, 1'b0);

    // Randomized traffic with variable bulb settle times.
    delay_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) issue(1'b1, 1'b0, rand_bcd(), 1'b0);
      else                           issue(1'b0, 1'($urandom), '0, 1'b0);
    end

    // Invalid BCD digit is clamped and flags error.
    issue(1'b1, 1'b0, 16'h05A3, 1'b0);

    // Stuck bulb: timeout after the full wait budget, then normal service.
    stuck = 4'b0001;
    fork
      issue(1'b0, 1'b0, '0, 1'b0);
      begin
        guard = 0;
        while (pl[0] !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
        while (pl[0] !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
        n = 0;
        while (!done && n < 500) begin n++; @(negedge clk); end
        chk("settle_timeout_cycles", n, TO);
      end
    join
    stuck = '0;
    issue(1'b0, 1'b1, '0, 1'b0);

    // Reset during the second phase of digit 1.
    issue(1'b1, 1'b0, 16'h0009, 1'b0);
    push_step(1'b0);
    @(negedge clk);
    req = 1'b1;
    dir = 1'b0;
    @(negedge clk);
    req = 1'b0;
    guard = 0;
    while (pl[1] !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
    chk("reached_digit1_ph2", pl[1], 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    res_q.delete();
    pulse_q.delete();
    setin_q.delete();
    model_v = 0;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Commands while busy are dropped, not queued.
    issue(1'b0, 1'b0, '0, 1'b1);
    repeat (10) @(negedge clk);
    chk("no_queued_cmd_busy", busy, 1'b0);
    chk("no_queued_cmd_value", value, int2bcd(model_v));
    chk("res_queue_empty", res_q.size(), 0);
    chk("pulse_queue_empty", pulse_q.size(), 0);
    chk("setin_queue_empty", setin_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
